// File: rtl/out_port_uart_tx_if.sv
// Purpose: bundles the output-port capture inputs and the UART/status outputs
//          of out_port_uart_tx into one interface.
// Signals:
//   din        processor output port value (uo_out)
//   cap_en     1 = sample din this cycle
//   tx         UART serial out, idle high
//   busy       frame on the line or FIFO non-empty
//   fifo_count FIFO occupancy, 0..FIFO_DEPTH
//   overflow   sticky: a captured value was dropped on a full FIFO
// Modports: master = producer/observer side, slave = the UART block.
interface out_port_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    din;
    logic          cap_en;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output din, cap_en,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  din, cap_en,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/out_port_uart_tx.sv
// Purpose: samples the processor output port every clock, queues each new
//          value in a small FIFO and serialises it as 8N1 UART frames.
//          Values arriving on a full FIFO are dropped and flagged (sticky).
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    out_port_uart_tx_if.slave: din/cap_en in; tx/busy/fifo_count/overflow out
module out_port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    out_port_uart_tx_if.slave    bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_tx, w_tx_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_last;
    logic          r_first;
    logic          r_ovf;

    logic w_pop, w_new, w_full, w_push, w_drop, w_baud_done;

    // Change detector: first sample after reset always counts as new.
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_new       = bus.cap_en && (r_first || (bus.din != r_last));
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_push      = w_new && (!w_full || w_pop);
    assign w_drop      = w_new && w_full && !w_pop;
    assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));

    // TX FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // TX FSM next-state; baud counter restarts on every state entry
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_baud_nxt  = r_baud + BW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                if (w_pop) begin
                    w_shift_nxt = r_mem[r_rd];
                    w_tx_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        // LSB is on the line; shift and present the next bit
                        w_tx_nxt    = r_shift[1];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Capture FIFO and change-detect state; dropped values still update last_val
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_last  <= 8'h00;
            r_first <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_new) begin
                r_last  <= bus.din;
                r_first <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked by pointers/count
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr] <= bus.din;
        end
    end

    assign bus.tx         = r_tx;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Self-checking bench for out_port_uart_tx: directed scenarios plus random
// traffic, compared every cycle against a frame-timing model.
module tb_out_port_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    out_port_uart_tx_if #(.FIFO_DEPTH(DEPTH)) intf ();

    out_port_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (intf.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of captured bytes; a frame is described only by its start edge and
    // byte: tx during bit slot k = (edge - start)/CPB is start/data/stop.
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    logic [7:0] m_byte;
    bit  m_first, m_ovf, m_in_frame, m_tx, m_valid = 0;
    bit  m_pop, m_new;
    int  m_n = 0, m_start = 0, m_k;

    always @(posedge clk) begin
        m_n++;
        if (rst) begin
            m_q.delete();
            m_first = 1; m_last = 8'h00; m_ovf = 0;
            m_in_frame = 0; m_tx = 1; m_valid = 1;
        end else begin
            m_pop = !m_in_frame && (m_q.size() != 0);
            if (m_in_frame && (m_n == m_start + 10*CPB)) m_in_frame = 0;
            if (m_pop) begin
                m_byte = m_q.pop_front();
                m_in_frame = 1;
                m_start = m_n;
            end
            m_new = intf.cap_en && (m_first || intf.din != m_last);
            if (m_new) begin
                m_first = 0;
                m_last  = intf.din;
                if (m_q.size() < DEPTH) m_q.push_back(intf.din);
                else m_ovf = 1;
            end
            if (m_in_frame) begin
                m_k = (m_n - m_start) / CPB;
                if (m_k == 0)      m_tx = 0;
                else if (m_k <= 8) m_tx = m_byte[m_k-1];
                else               m_tx = 1;
            end else begin
                m_tx = 1;
            end
        end
    end

    // Per-cycle compare, away from the active edge
    int peak = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",         int'(intf.tx),         int'(m_tx));
            chk("busy",       int'(intf.busy),       int'(m_in_frame || m_q.size() != 0));
            chk("fifo_count", int'(intf.fifo_count), m_q.size());
            chk("overflow",   int'(intf.overflow),   int'(m_ovf));
            if (int'(intf.fifo_count) > peak) peak = int'(intf.fifo_count);
        end
    end

    // Independent UART receiver: mid-bit sampling of tx
    logic [7:0] rx_q[$];
    logic [7:0] rx_b;
    bit rx_act = 0;
    int rx_t = 0;
    always @(negedge clk) begin
        if (rst) begin
            rx_act = 0;
        end else begin
            if (!rx_act && intf.tx == 1'b0) begin
                rx_act = 1;
                rx_t   = 0;
            end
            if (rx_act) begin
                if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 2) % 4) == 0)
                    rx_b[(rx_t-6)/4] = intf.tx;
                if (rx_t == 38) begin
                    rx_q.push_back(rx_b);
                    rx_act = 0;
                end
                rx_t++;
            end
        end
    end

    // Inputs change 2 time units after the active edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        step();
        rst = 1; intf.cap_en = 0;
        repeat (cycles) step();
        rst = 0;
        rx_q.delete();
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_frames"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            chk({nm, "_byte"}, int'(rx_q[i]), int'(exp[i]));
    endtask

    logic [9:0] a5_line;
    logic [7:0] exp_q[$];

    initial begin
        intf.din = 8'h00;
        intf.cap_en = 0;
        // 1: reset state, stays quiet with cap_en=0
        do_reset(2);
        repeat (5) step();
        @(negedge clk);
        chk("rst_tx", int'(intf.tx), 1);
        chk("rst_busy", int'(intf.busy), 0);
        chk("rst_count", int'(intf.fifo_count), 0);
        chk("rst_ovf", int'(intf.overflow), 0);

        // 2: single frame of A5, exact line pattern
        a5_line = 10'b1101001010;   // bit i = tx during slot i (start, LSB.., stop)
        step();
        intf.din = 8'hA5; intf.cap_en = 1;
        @(posedge clk);   // push
        @(posedge clk);   // pop, tx low
        for (int i = 0; i < 10*CPB; i++) begin
            @(negedge clk);
            chk("a5_line", int'(intf.tx), int'(a5_line[i/CPB]));
        end
        @(negedge clk);
        chk("a5_busy_end", int'(intf.busy), 0);
        repeat (50) step();
        exp_q = '{8'hA5};
        chk_rx("a5", exp_q);

        // 3: first-flag capture of 8'h00
        do_reset(2);
        step();
        intf.din = 8'h00; intf.cap_en = 1;
        repeat (100) step();
        exp_q = '{8'h00};
        chk_rx("zero", exp_q);

        // 4: six distinct values back to back, sixth dropped
        do_reset(2);
        peak = 0;
        intf.cap_en = 1;
        for (int i = 1; i <= 6; i++) begin
            intf.din = 8'(i * 8'h11);
            step();
        end
        intf.cap_en = 0;
        repeat (6 * 45) step();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk_rx("burst", exp_q);
        chk("burst_peak", peak, 4);
        @(negedge clk);
        chk("burst_ovf", int'(intf.overflow), 1);

        // 5: cap_en gating, then re-enable with changed value
        do_reset(2);
        intf.din = 8'h01; intf.cap_en = 1;
        step();
        intf.cap_en = 0;
        repeat (50) step();
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            intf.din = (i % 2 == 0) ? 8'h02 : 8'h01;
            step();
        end
        @(negedge clk);
        chk("gate_count", int'(intf.fifo_count), 0);
        chk("gate_frames", rx_q.size(), 0);
        step();
        intf.din = 8'h02; intf.cap_en = 1;
        repeat (60) step();
        intf.cap_en = 0;
        exp_q = '{8'h02};
        chk_rx("gate", exp_q);

        // 6: reset in DATA of 3C with two entries queued
        do_reset(2);
        intf.din = 8'h3C; intf.cap_en = 1;
        step();
        intf.din = 8'h77;
        step();
        intf.din = 8'h88;
        step();
        intf.cap_en = 0;
        repeat (12) step();
        rst = 1;
        step();
        rst = 0;
        rx_q.delete();
        @(negedge clk);
        chk("mid_rst_tx", int'(intf.tx), 1);
        chk("mid_rst_count", int'(intf.fifo_count), 0);
        chk("mid_rst_busy", int'(intf.busy), 0);
        chk("mid_rst_ovf", int'(intf.overflow), 0);
        repeat (100) step();
        chk("mid_rst_frames", rx_q.size(), 0);

        // Random traffic: small value alphabet to hit repeats, rare resets
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            intf.cap_en = ($urandom_range(0, 3) != 0);
            intf.din = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 0; intf.cap_en = 0;
        repeat (300) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
